wb_slave_mux: RTL and testbench

- Parametrised Wishbone address decoder and response multiplexer for the user project area.
- Routes one Wishbone master (the management core) to N_SLAVES downstream slaves, such as UART, BRAM and future peripherals, by matching the top address byte.
- Adds behaviour the two-slave decoder lacks:
  - per-transaction state machine;
  - ack timeout watchdog;
  - error termination for unmapped addresses and hung slaves;
  - one-cycle turnaround after every response.

---
 rtl/wb_mux_pkg.sv | 22 ++
 rtl/wb_mux_decode.sv | 24 ++
 rtl/wb_slave_mux.sv | 183 ++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_pkg.sv
// rtl/wb_mux_pkg.sv - shared types and constants for the Wishbone slave mux
package wb_mux_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int DEC_MSB = 31;
    localparam int DEC_LSB = 24;

    // Status window: top address byte and register offsets
    localparam logic [7:0] STAT_BASE       = 8'hFF;
    localparam logic [7:0] STAT_OFF_TO     = 8'h00;
    localparam logic [7:0] STAT_OFF_UNMAP  = 8'h04;
    localparam logic [7:0] STAT_OFF_ERRADR = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR,
        DONE
    } state_t;

endpackage

// File: rtl/wb_mux_decode.sv
// rtl/wb_mux_decode.sv - priority match of an address byte against a table of slave bases
module wb_mux_decode #(
    parameter int                    N_SLAVES   = 2,
    parameter logic [N_SLAVES*8-1:0] SLAVE_BASE = {8'h38, 8'h30},
    parameter int                    IW         = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [7:0]    adr_byte,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest matching index is the last one written and wins
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (adr_byte == SLAVE_BASE[i*8 +: 8]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone decoder/response mux with timeout; WB_SLAVE_MUX_STATUS_EN adds a status window
module wb_slave_mux
    import wb_mux_pkg::*;
#(
    parameter int                    N_SLAVES       = 2,
    parameter logic [N_SLAVES*8-1:0] SLAVE_BASE     = {8'h38, 8'h30},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [WB_DW-1:0]      ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [WB_DW-1:0]       wbs_dat_i,
    input  logic [WB_AW-1:0]       wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [WB_DW-1:0]       wbs_dat_o,
    output logic [N_SLAVES-1:0]    s_valid_o,
    input  logic [N_SLAVES-1:0]    s_ack_i,
    input  logic [N_SLAVES*32-1:0] s_dat_i,
    output logic                   bus_err_o
);

    localparam int          IW      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [IW-1:0]     sel_q;
    logic [15:0]       to_cnt;
    logic              stat_q;
    logic              req;
    logic              dec_hit;
    logic [IW-1:0]     dec_idx;
    logic              sel_ack;
    logic [WB_DW-1:0]  sel_dat;
    logic              stat_hit;
    logic [WB_DW-1:0]  stat_dat;

    // Write-side bus signals go straight to the slaves; nothing here consumes them
    logic unused_inputs;
    assign unused_inputs = ^{wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i[DEC_LSB-1:0]};

    assign req     = wbs_cyc_i && wbs_stb_i;
    assign sel_ack = s_ack_i[sel_q];

    wb_mux_decode #(
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .IW         (IW)
    ) u_decode (
        .adr_byte (wbs_adr_i[DEC_MSB:DEC_LSB]),
        .hit      (dec_hit),
        .idx      (dec_idx)
    );

    // Read data of the latched slave
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == IW'(i)) sel_dat = s_dat_i[i*32 +: 32];
        end
    end

`ifdef WB_SLAVE_MUX_STATUS_EN
    logic [15:0]      to_count;
    logic [15:0]      unmap_count;
    logic [WB_AW-1:0] last_err_adr;
    logic             to_event;
    logic             unmap_event;
    logic             stat_clear;

    assign stat_hit    = (wbs_adr_i[DEC_MSB:DEC_LSB] == STAT_BASE);
    assign to_event    = (state == WAIT) && !stat_q && req && !sel_ack && (to_cnt == TO_LAST);
    assign unmap_event = (state == IDLE) && req && !stat_hit && !dec_hit;
    assign stat_clear  = (state == WAIT) && stat_q && req && wbs_we_i &&
                         (wbs_adr_i[7:0] == STAT_OFF_TO);

    // Status register read mux
    always_comb begin
        stat_dat = '0;
        case (wbs_adr_i[7:0])
            STAT_OFF_TO:     stat_dat = {16'h0, to_count};
            STAT_OFF_UNMAP:  stat_dat = {16'h0, unmap_count};
            STAT_OFF_ERRADR: stat_dat = last_err_adr;
            default:         stat_dat = '0;
        endcase
    end

    // Saturating error counters and last error address
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_count     <= '0;
            unmap_count  <= '0;
            last_err_adr <= '0;
        end else begin
            if (stat_clear) begin
                to_count    <= '0;
                unmap_count <= '0;
            end
            if (to_event && to_count != 16'hFFFF) to_count <= to_count + 16'd1;
            if (unmap_event && unmap_count != 16'hFFFF) unmap_count <= unmap_count + 16'd1;
            if (to_event || unmap_event) last_err_adr <= wbs_adr_i;
        end
    end
`else
    assign stat_hit = 1'b0;
    assign stat_dat = '0;
`endif

    // Per-transaction state machine with timeout watchdog
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            sel_q  <= '0;
            to_cnt <= '0;
            stat_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (stat_hit) begin
                            stat_q <= 1'b1;
                            to_cnt <= '0;
                            state  <= WAIT;
                        end else if (dec_hit) begin
                            stat_q <= 1'b0;
                            sel_q  <= dec_idx;
                            to_cnt <= '0;
                            state  <= WAIT;
                        end else begin
                            state  <= ERR;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (stat_q || sel_ack) begin
                        state <= DONE;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ERR:     state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response mux; forced quiet while reset is held so an aborted access never acks
    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        s_valid_o = '0;
        bus_err_o = 1'b0;
        if (!wb_rst_i) begin
            case (state)
                WAIT: begin
                    if (stat_q) begin
                        wbs_ack_o = req;
                        wbs_dat_o = stat_dat;
                    end else begin
                        s_valid_o[sel_q] = req;
                        wbs_ack_o        = sel_ack && req;
                        wbs_dat_o        = sel_dat;
                    end
                end
                ERR: begin
                    wbs_ack_o = req;
                    wbs_dat_o = ERR_DATA;
                    bus_err_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - scoreboard bench for wb_slave_mux
module tb_wb_slave_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        cyc_i;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_r;
    logic [1:0]  s_valid;
    logic [1:0]  s_ack;
    logic [63:0] s_dat;
    logic        bus_err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          at;
    } exp_t;

    exp_t exp_q[$];

    wb_slave_mux #(
        .N_SLAVES       (2),
        .SLAVE_BASE     ({8'h38, 8'h30}),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc_i),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_w),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .s_valid_o (s_valid),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_dat),
        .bus_err_o (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack cyc=%0d dat=%h err=%b", cyc, dat_r, bus_err);
            end else begin
                e = exp_q.pop_front();
                if (dat_r !== e.dat || bus_err !== e.err || cyc != e.at) begin
                    errors++;
                    $display("FAIL ack_resp got dat=%h err=%b cyc=%0d exp dat=%h err=%b cyc=%0d",
                             dat_r, bus_err, cyc, e.dat, e.err, e.at);
                end
            end
        end else if (bus_err) begin
            checks++;
            errors++;
            $display("FAIL stray_bus_err cyc=%0d", cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // One master access; the non-target slave acks constantly with junk data
    task automatic access(input logic [31:0] a, input logic w, input int tgt, input int waits,
                          input logic [31:0] sdat, input logic [31:0] exp_dat, input logic exp_err,
                          input int lat, input int vcyc, input bit hold_extra);
        logic [1:0] tmask;
        bit         got;
        exp_t       e;
        tmask = 2'b01 << tgt;
        @(posedge clk); #1;
        e.dat = exp_dat;
        e.err = exp_err;
        e.at  = cyc + lat;
        exp_q.push_back(e);
        cyc_i = 1'b1;
        stb   = 1'b1;
        adr   = a;
        we    = w;
        dat_w = 32'h0BAD_F00D;
        s_dat[tgt*32 +: 32]       = sdat;
        s_dat[(1 - tgt)*32 +: 32] = 32'hBAD0_BAD0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            s_ack = ~tmask | ((n == waits + 1) ? tmask : 2'b00);
            @(negedge clk);
            chk("s_valid", {30'h0, s_valid}, {30'h0, (n >= 1 && n <= vcyc) ? tmask : 2'b00});
            got = ack;
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait_bound adr=%h got no ack exp ack", a);
        end
        if (hold_extra) begin
            s_ack = 2'b11;
            @(negedge clk);
            chk("done_valid", {30'h0, s_valid}, 32'h0);
            @(posedge clk); #1;
        end
        cyc_i = 1'b0;
        stb   = 1'b0;
        s_ack = 2'b00;
    endtask

    initial begin
        rst   = 1'b1;
        stb   = 1'b0;
        cyc_i = 1'b0;
        we    = 1'b0;
        sel   = 4'hF;
        dat_w = 32'h0;
        adr   = 32'h0;
        s_ack = 2'b00;
        s_dat = 64'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_r, 32'h0);
        chk("rst_valid", {30'h0, s_valid}, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Read with two wait states, master holds stb through DONE
        access(32'h3000_0004, 1'b0, 0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 3, 1'b1);
        // Zero-wait write to slave1
        access(32'h3800_0010, 1'b1, 1, 0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1, 1, 1'b0);
        // Unmapped read, issued back-to-back
        access(32'h2000_0000, 1'b0, 0, 100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 1'b0);
        // Top byte FF is unmapped without the status window
        access(32'hFF00_0000, 1'b0, 0, 100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 1'b0);
        // Slave0 never acks: error after eight WAIT cycles
        access(32'h3000_0000, 1'b0, 0, 100, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 9, 8, 1'b0);
        // Ack on the eighth WAIT cycle beats the timeout
        access(32'h3000_0000, 1'b0, 0, 7, 32'hCAFE_0008, 32'hCAFE_0008, 1'b0, 8, 8, 1'b0);

        // Master abandons after three WAIT cycles
        @(posedge clk); #1;
        cyc_i = 1'b1;
        stb   = 1'b1;
        adr   = 32'h3000_0008;
        we    = 1'b0;
        s_ack = 2'b00;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("drop_valid", {30'h0, s_valid}, (n >= 1) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        cyc_i = 1'b0;
        stb   = 1'b0;
        @(negedge clk);
        chk("drop_valid_off", {30'h0, s_valid}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_idle_valid", {30'h0, s_valid}, 32'h0);
        access(32'h3000_000C, 1'b0, 0, 0, 32'h0000_0C0C, 32'h0000_0C0C, 1'b0, 1, 1, 1'b0);

        // Reset in the middle of a WAIT to slave1
        @(posedge clk); #1;
        cyc_i = 1'b1;
        stb   = 1'b1;
        adr   = 32'h3800_0000;
        s_ack = 2'b00;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("prerst_valid", {30'h0, s_valid}, (n >= 1) ? 32'h2 : 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        cyc_i = 1'b0;
        stb   = 1'b0;
        @(negedge clk);
        chk("postrst_ack", {31'h0, ack}, 32'h0);
        chk("postrst_valid", {30'h0, s_valid}, 32'h0);
        chk("postrst_dat", dat_r, 32'h0);
        chk("postrst_err", {31'h0, bus_err}, 32'h0);
        access(32'h3800_0000, 1'b0, 1, 1, 32'h7777_0001, 32'h7777_0001, 1'b0, 2, 2, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
